// File: rtl/ram_burst_master.sv
// Burst initiator for the single-port RAM: turns write/read burst commands into
// cycle-by-cycle address/data/select/write sequencing, one beat per two cycles.
module ram_burst_master #(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 8,
  parameter int LEN_W  = 11
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_write,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [LEN_W-1:0]  cmd_len,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              wr_valid,
  output logic              wr_ready,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_valid,
  input  logic              rd_ready,
  output logic              done,
  output logic              busy,
  output logic [ADDR_W-1:0] mem_address,
  output logic [DATA_W-1:0] mem_data_in,
  input  logic [DATA_W-1:0] mem_data_out,
  output logic              mem_write,
  output logic              mem_select
);

  typedef enum logic [2:0] {
    IDLE, WR_WAIT, WR_STROBE, RD_ISSUE, RD_WAIT, DONE
  } state_t;

  state_t            state, state_nxt;
  logic [ADDR_W-1:0] cur_addr, cur_addr_nxt;
  logic [LEN_W-1:0]  remaining, remaining_nxt;
  logic [ADDR_W-1:0] mem_address_nxt;
  logic [DATA_W-1:0] mem_data_in_nxt, rd_data_nxt;
  logic              mem_write_nxt, mem_select_nxt, rd_valid_nxt, done_nxt;
  logic              last_beat;

  assign last_beat = (remaining == LEN_W'(1));
  assign cmd_ready = (state == IDLE);
  assign wr_ready  = (state == WR_WAIT);
  assign busy      = (state != IDLE);

  always_comb begin
    // NOTE: every output of this block is given a default first, so no path
    // leaves a variable unassigned and no latch is inferred.
    state_nxt       = state;
    cur_addr_nxt    = cur_addr;
    remaining_nxt   = remaining;
    mem_address_nxt = mem_address;
    mem_data_in_nxt = mem_data_in;
    mem_write_nxt   = mem_write;
    mem_select_nxt  = mem_select;
    rd_data_nxt     = rd_data;
    rd_valid_nxt    = rd_valid;
    done_nxt        = 1'b0;

    unique case (state)
      IDLE: begin
        if (cmd_valid) begin
          cur_addr_nxt  = cmd_addr;
          remaining_nxt = cmd_len;
          if (cmd_len == '0) begin
            state_nxt = DONE;
            done_nxt  = 1'b1;
          end else if (cmd_write) begin
            state_nxt = WR_WAIT;
          end else begin
            state_nxt       = RD_ISSUE;
            mem_address_nxt = cmd_addr;
            mem_select_nxt  = 1'b1;
            mem_write_nxt   = 1'b0;
          end
        end
      end
      WR_WAIT: begin
        if (wr_valid) begin
          mem_address_nxt = cur_addr;
          mem_data_in_nxt = wr_data;
          mem_write_nxt   = 1'b1;
          mem_select_nxt  = 1'b1;
          state_nxt       = WR_STROBE;
        end
      end
      WR_STROBE: begin
        // The strobe has been visible for one full cycle; the RAM takes it at this edge.
        mem_write_nxt  = 1'b0;
        mem_select_nxt = 1'b0;
        cur_addr_nxt   = cur_addr + ADDR_W'(1);
        remaining_nxt  = remaining - LEN_W'(1);
        if (last_beat) begin
          state_nxt = DONE;
          done_nxt  = 1'b1;
        end else begin
          state_nxt = WR_WAIT;
        end
      end
      RD_ISSUE: begin
        rd_data_nxt    = mem_data_out;
        rd_valid_nxt   = 1'b1;
        mem_select_nxt = 1'b0;
        state_nxt      = RD_WAIT;
      end
      RD_WAIT: begin
        if (rd_ready) begin
          rd_valid_nxt  = 1'b0;
          cur_addr_nxt  = cur_addr + ADDR_W'(1);
          remaining_nxt = remaining - LEN_W'(1);
          if (last_beat) begin
            state_nxt = DONE;
            done_nxt  = 1'b1;
          end else begin
            // Next read address is registered on entry so the RAM sees it for the whole issue cycle.
            state_nxt       = RD_ISSUE;
            mem_address_nxt = cur_addr + ADDR_W'(1);
            mem_select_nxt  = 1'b1;
            mem_write_nxt   = 1'b0;
          end
        end
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // NOTE: the async reset clears every register, so an abandoned burst drops
  // mem_write/mem_select the instant rst_n falls, not at the next edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      cur_addr    <= '0;
      remaining   <= '0;
      mem_address <= '0;
      mem_data_in <= '0;
      mem_write   <= 1'b0;
      mem_select  <= 1'b0;
      rd_data     <= '0;
      rd_valid    <= 1'b0;
      done        <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      state       <= state_nxt;
      cur_addr    <= cur_addr_nxt;
      remaining   <= remaining_nxt;
      mem_address <= mem_address_nxt;
      mem_data_in <= mem_data_in_nxt;
      mem_write   <= mem_write_nxt;
      mem_select  <= mem_select_nxt;
      rd_data     <= rd_data_nxt;
      rd_valid    <= rd_valid_nxt;
      done        <= done_nxt;
    end
  end

endmodule
